// File: rtl/text_stream_reader.sv
// Captures an ioctl text download into a local buffer, then replays it byte
// by byte over a valid/ready stream with CR/LF/NUL/Ctrl-Z filtering and
// per-character / per-line pacing gaps.
module text_stream_reader #(
  parameter int          ADDR_W   = 13,
  parameter int unsigned CHAR_GAP = 50000,
  parameter int unsigned LINE_GAP = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int          LEN_W   = ADDR_W + 1;
  localparam int unsigned GAP_MAX = (LINE_GAP > CHAR_GAP) ? LINE_GAP : CHAR_GAP;
  localparam int          GAP_W   = $clog2(GAP_MAX + 2);

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_EOT = 8'h1A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_WAIT_RD,
    S_PRESENT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic [LEN_W-1:0]  length_q, length_d;
  logic [LEN_W-1:0]  ptr_q, ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              prev_cr_q, prev_cr_d;

  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        rd_data_q;

  logic              dl_rise;
  logic              dl_fall;
  logic              wr_en;
  logic [LEN_W-1:0]  wr_len;
  logic [LEN_W-1:0]  len_base;
  logic [LEN_W-1:0]  ptr_inc;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  // Writes are accepted in LOAD and on the very cycle LOAD is being entered.
  assign wr_en   = ioctl_download & ioctl_wr & ((state_q == S_LOAD) | dl_rise);
  assign wr_len  = {1'b0, ioctl_addr} + LEN_W'(1);
  assign ptr_inc = ptr_q + LEN_W'(1);

  // Text buffer: write port from ioctl, registered read at the playback pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ioctl_addr] <= ioctl_dout;
    end
    rd_data_q <= mem[ptr_q[ADDR_W-1:0]];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      length_q    <= '0;
      ptr_q       <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prev_cr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      length_q    <= length_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prev_cr_q   <= prev_cr_d;
    end
  end

  // Next-state logic: download capture, filtering playback and pacing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    prev_cr_d   = prev_cr_q;
    len_base    = length_q;

    // A new download pre-empts whatever is in progress, without a done pulse.
    if (dl_rise) begin
      state_d     = S_LOAD;
      len_base    = '0;
      busy_d      = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          if (dl_fall) begin
            if (length_q == '0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d   = S_FETCH;
              ptr_d     = '0;
              prev_cr_d = 1'b0;
            end
          end
        end
        S_FETCH: begin
          state_d = S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (rd_data_q == CH_EOT) begin
            state_d = S_FINISH;
          end else if ((rd_data_q == CH_NUL) || ((rd_data_q == CH_LF) && prev_cr_q)) begin
            ptr_d   = ptr_inc;
            state_d = (ptr_inc == length_q) ? S_FINISH : S_FETCH;
          end else begin
            out_data_d  = (rd_data_q == CH_LF) ? CH_CR : rd_data_q;
            out_valid_d = 1'b1;
            state_d     = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            ptr_d       = ptr_inc;
            prev_cr_d   = (out_data_q == CH_CR);
            gap_d       = (out_data_q == CH_CR) ? GAP_W'(LINE_GAP) : GAP_W'(CHAR_GAP);
            state_d     = S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_d = (ptr_q == length_q) ? S_FINISH : S_FETCH;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    length_d = len_base;
    if (wr_en && (wr_len > len_base)) begin
      length_d = wr_len;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_text_stream_reader.sv
// Directed + randomized bench for text_stream_reader with a behavioural
// model of the filtered output stream.
module tb_text_stream_reader;

  localparam int          ADDR_W   = 8;
  localparam int unsigned CHAR_GAP = 2;
  localparam int unsigned LINE_GAP = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [7:0] file_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int  cyc = 0;
  int  done_cnt = 0;
  int  done_busy_bad = 0;
  int  gap_bad = 0;
  int  idle_run = 0;
  bit  have_last = 0;
  logic [7:0] last_byte = 8'h00;
  bit  valid_seen = 0;
  bit  rand_ready = 0;
  logic busy_prev = 1'b0;

  text_stream_reader #(
    .ADDR_W  (ADDR_W),
    .CHAR_GAP(CHAR_GAP),
    .LINE_GAP(LINE_GAP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) valid_seen = 1;
      if (out_valid && out_ready) begin
        if (have_last) begin
          if (idle_run < int'((last_byte == 8'h0D) ? LINE_GAP : CHAR_GAP)) gap_bad++;
        end
        got_q.push_back(out_data);
        have_last = 1;
        last_byte = out_data;
        idle_run  = 0;
      end else if (!out_valid) begin
        idle_run++;
      end
      if (done) begin
        done_cnt++;
        if (busy !== 1'b0 || busy_prev !== 1'b1) done_busy_bad++;
      end
      busy_prev = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Expected output: Ctrl-Z ends the text, NULs vanish, LF after a delivered
  // CR vanishes, any other LF becomes CR.
  task automatic build_expect();
    bit prev_cr = 0;
    exp_q.delete();
    foreach (file_q[i]) begin
      logic [7:0] b = file_q[i];
      if (b == 8'h1A) break;
      if (b == 8'h00) continue;
      if (b == 8'h0A && prev_cr) continue;
      if (b == 8'h0A) b = 8'h0D;
      exp_q.push_back(b);
      prev_cr = (b == 8'h0D);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_cnt      = 0;
    done_busy_bad = 0;
    gap_bad       = 0;
    have_last     = 0;
    valid_seen    = 0;
  endtask

  task automatic download(input bit rev);
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int k = 0; k < file_q.size(); k++) begin
      int i;
      i = rev ? (file_q.size() - 1 - k) : k;
      ioctl_addr = ADDR_W'(i);
      ioctl_dout = file_q[i];
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
      tick();
    end
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < max_cyc), 32'd1);
    rand_ready = 0;
    out_ready  = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    build_expect();
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_done"}, 32'(done_busy_bad), 32'd0);
    check({tag, "_gap"}, 32'(gap_bad), 32'd0);
  endtask

  task automatic set_file(input string s);
    file_q.delete();
    for (int i = 0; i < s.len(); i++) file_q.push_back(8'(s[i]));
  endtask

  task automatic rand_file(input int n, input bit specials);
    file_q.delete();
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (specials && r == 0)                   file_q.push_back(8'h00);
      else if (specials && (r == 1 || r == 2))  file_q.push_back(8'h0A);
      else if (specials && (r == 3 || r == 4))  file_q.push_back(8'h0D);
      else if (specials && r == 5 && $urandom_range(0, 3) == 0) file_q.push_back(8'h1A);
      else file_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
    end
  endtask

  initial begin
    logic [7:0] held;
    int unstable;
    int n;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    out_ready      = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {20'd0, out_valid, out_data, busy, done}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic line, one CR at the end.
    clear_obs();
    set_file("PRINT 1\n");
    download(0);
    wait_idle("print", 2000);
    compare_stream("print");
    check("print_last_cr", 32'(got_q.size() == 8 ? got_q[7] : 8'hFF), 32'h0D);

    // CR LF collapsing and lone LF conversion, written highest address first.
    clear_obs();
    file_q = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A};
    download(1);
    wait_idle("crlf", 2000);
    compare_stream("crlf");

    // NUL skip and Ctrl-Z termination.
    clear_obs();
    file_q = '{8'h41, 8'h00, 8'h42, 8'h1A, 8'h43};
    download(0);
    wait_idle("eot", 2000);
    compare_stream("eot");

    // Backpressure: hold the first byte for 20 cycles.
    clear_obs();
    set_file("AB");
    out_ready = 1'b0;
    download(0);
    wait_valid("bp_valid");
    held = out_data;
    unstable = 0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== held) unstable++;
    end
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_no_transfer", 32'(got_q.size()), 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_one_transfer", 32'(got_q.size()), 32'd1);
    wait_idle("bp", 2000);
    compare_stream("bp");

    // Zero-length download.
    clear_obs();
    ioctl_download = 1'b1;
    tick();
    tick();
    check("zero_busy_high", 32'(busy), 32'd1);
    tick();
    ioctl_download = 1'b0;
    repeat (6) tick();
    check("zero_busy_low", 32'(busy), 32'd0);
    check("zero_no_valid", 32'(valid_seen), 32'd0);
    check("zero_no_done", 32'(done_cnt), 32'd0);

    // Randomized files with random consumer readiness.
    for (int t = 0; t < 4; t++) begin
      clear_obs();
      rand_file($urandom_range(1, 40), 1);
      download(bit'(t & 1));
      rand_ready = 1;
      wait_idle($sformatf("rand%0d", t), 8000);
      compare_stream($sformatf("rand%0d", t));
    end

    // Completely full buffer.
    clear_obs();
    rand_file(2**ADDR_W, 0);
    download(0);
    wait_idle("full", 20000);
    compare_stream("full");

    // Abort mid-playback with a new download.
    clear_obs();
    rand_file(100, 0);
    held = file_q[0];
    download(0);
    n = 0;
    while (got_q.size() < 5 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_progress", 32'(got_q.size() >= 5), 32'd1);
    check("abort_first_byte", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'(held));
    out_ready = 1'b0;
    wait_valid("abort_valid");
    ioctl_download = 1'b1;
    tick();
    check("abort_valid_drop", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    clear_obs();
    set_file("XYZ\n");
    download(0);
    wait_idle("abort2", 2000);
    compare_stream("abort2");

    // Reset while a byte is presented.
    clear_obs();
    set_file("QR");
    out_ready = 1'b0;
    download(0);
    wait_valid("rst_valid");
    reset = 1'b1;
    tick();
    check("rst_outputs", {20'd0, out_valid, out_data, busy, done}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_no_transfer", 32'(got_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
